// File: rtl/ce_lsr_gen.sv
// ce_lsr_gen: clock-enable / local set-reset generator for CE_OVER_LSR register banks.
//
// A free-running prescaler produces a one-cycle clock-enable strobe (SP_O)
// every div_q+1 cycles. A small FSM holds the local reset (SR_O) high for
// exactly HOLD_TICKS enable pulses after global reset or after a clear
// request. Downstream cells therefore see SP&SR together on HOLD_TICKS edges.
//
// Ports:
//   CK       in   clock, all logic on rising edge
//   SR       in   synchronous active-high reset, overrides everything
//   DIV      in   prescale value, enable period = DIV+1 cycles (sampled at wrap)
//   CLR_REQ  in   request to re-run the local-reset sequence (only honoured in RUN)
//   SP_O     out  registered one-cycle clock-enable strobe
//   SR_O     out  registered local set/reset
//   BUSY     out  high while a hold (reset or clear) sequence is in progress
//   DONE     out  one-cycle pulse when a hold sequence completes
module ce_lsr_gen #(
  parameter int DIV_W      = 8,
  parameter int HOLD_TICKS = 4
) (
  input  logic             CK,
  input  logic             SR,
  input  logic [DIV_W-1:0] DIV,
  input  logic             CLR_REQ,
  output logic             SP_O,
  output logic             SR_O,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);

  // Initialisers mirror the reset state so simulation starts sane before SR.
  // div_q cannot copy DIV at power-up, so it starts at zero until the first SR.
  logic [DIV_W-1:0] cnt_q   = '0;
  logic [DIV_W-1:0] div_q   = '0;
  logic             sp_q    = 1'b0;
  logic             sr_q    = 1'b1;
  logic             busy_q  = 1'b1;
  logic             done_q  = 1'b0;
  logic [7:0]       hcnt_q  = 8'd0;
  state_t           state_q = ST_HOLD;

  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] div_d;
  logic             sp_d;
  logic             sr_d;
  logic             busy_d;
  logic             done_d;
  logic [7:0]       hcnt_d;
  state_t           state_d;

  // Prescaler: DIV is only sampled at the wrap, so mid-period changes take
  // effect from the following period. It never restarts on CLEAR.
  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    div_d = div_q;
    sp_d  = 1'b0;
    if (cnt_q == div_q) begin
      cnt_d = '0;
      div_d = DIV;
      sp_d  = 1'b1;
    end
  end

  // Hold FSM: counts registered enable pulses, so the pulse that completes
  // the count is the last edge on which downstream cells see SP&SR together.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_HOLD, ST_CLEAR: begin
        // CLR_REQ is deliberately not looked at here: no queuing.
        if (sp_q) begin
          if (hcnt_q == HOLD_LAST) begin
            state_d = ST_RUN;
            hcnt_d  = 8'd0;
            done_d  = 1'b1;
          end else begin
            hcnt_d = hcnt_q + 8'd1;
          end
        end
      end
      ST_RUN: begin
        if (CLR_REQ) begin
          state_d = ST_CLEAR;
          hcnt_d  = 8'd0;
        end
      end
      default: begin
        state_d = ST_HOLD;
        hcnt_d  = 8'd0;
      end
    endcase
    sr_d   = (state_d != ST_RUN);
    busy_d = (state_d != ST_RUN);
  end

  always_ff @(posedge CK) begin
    if (SR) begin
      cnt_q   <= '0;
      div_q   <= DIV;
      sp_q    <= 1'b0;
      sr_q    <= 1'b1;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      hcnt_q  <= 8'd0;
      state_q <= ST_HOLD;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      sp_q    <= sp_d;
      sr_q    <= sr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hcnt_q  <= hcnt_d;
      state_q <= state_d;
    end
  end

  assign SP_O = sp_q;
  assign SR_O = sr_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_ce_lsr_gen.sv
// Directed bench for ce_lsr_gen. Instance u_a uses HOLD_TICKS=4 with DIV=2
// (later 5), instance u_b uses HOLD_TICKS=1 with DIV=0. Edge 0 is the reset
// edge; outputs are sampled 1 time unit after each rising edge.
module tb_ce_lsr_gen;

  logic       ck = 1'b0;
  logic       sr_a, clr_a, sp_a, sro_a, busy_a, done_a;
  logic [7:0] div_a;
  logic       sr_b, clr_b, sp_b, sro_b, busy_b, done_b;
  logic [7:0] div_b;

  int n_tot = 0;
  int n_bad = 0;
  int ecnt  = -1;
  int base;

  always #5 ck = ~ck;

  ce_lsr_gen #(.DIV_W(8), .HOLD_TICKS(4)) u_a (
    .CK(ck), .SR(sr_a), .DIV(div_a), .CLR_REQ(clr_a),
    .SP_O(sp_a), .SR_O(sro_a), .BUSY(busy_a), .DONE(done_a)
  );

  ce_lsr_gen #(.DIV_W(8), .HOLD_TICKS(1)) u_b (
    .CK(ck), .SR(sr_b), .DIV(div_b), .CLR_REQ(clr_b),
    .SP_O(sp_b), .SR_O(sro_b), .BUSY(busy_b), .DONE(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, ecnt, got, exp);
    end
  endtask

  task automatic expect_a(input logic sp, input logic sro, input logic bsy, input logic dn);
    chk("a_sp",   {31'b0, sp_a},   {31'b0, sp});
    chk("a_sr",   {31'b0, sro_a},  {31'b0, sro});
    chk("a_busy", {31'b0, busy_a}, {31'b0, bsy});
    chk("a_done", {31'b0, done_a}, {31'b0, dn});
  endtask

  task automatic expect_b(input logic sp, input logic sro, input logic bsy, input logic dn);
    chk("b_sp",   {31'b0, sp_b},   {31'b0, sp});
    chk("b_sr",   {31'b0, sro_b},  {31'b0, sro});
    chk("b_busy", {31'b0, busy_b}, {31'b0, bsy});
    chk("b_done", {31'b0, done_b}, {31'b0, dn});
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
    ecnt++;
  endtask

  initial begin
    sr_a = 1'b1; div_a = 8'd2; clr_a = 1'b0;
    sr_b = 1'b1; div_b = 8'd0; clr_b = 1'b0;

    // Reset edge
    tick();
    expect_a(1'b0, 1'b1, 1'b1, 1'b0);
    expect_b(1'b0, 1'b1, 1'b1, 1'b0);
    sr_a = 1'b0;
    sr_b = 1'b0;

    // Initial HOLD: A strobes on edges 3,6,9,12 and releases on 13;
    // B strobes every edge, releases on 2, then runs a one-tick CLEAR.
    for (int e = 1; e <= 14; e++) begin
      tick();
      expect_a(ecnt % 3 == 0, ecnt < 13, ecnt < 13, ecnt == 13);
      case (ecnt)
        1: expect_b(1'b1, 1'b1, 1'b1, 1'b0);
        2: expect_b(1'b1, 1'b0, 1'b0, 1'b1);
        3: begin expect_b(1'b1, 1'b0, 1'b0, 1'b0); clr_b = 1'b1; end
        4: begin expect_b(1'b1, 1'b1, 1'b1, 1'b0); clr_b = 1'b0; end
        5: expect_b(1'b1, 1'b0, 1'b0, 1'b1);
        6: expect_b(1'b1, 1'b0, 1'b0, 1'b0);
        default: ;
      endcase
    end

    // One-cycle CLEAR pulse in RUN (edge 15); strobes counted on 16,19,22,25
    clr_a = 1'b1;
    tick();
    expect_a(1'b1, 1'b1, 1'b1, 1'b0);
    clr_a = 1'b0;
    for (int e = 16; e <= 26; e++) begin
      tick();
      expect_a(ecnt % 3 == 0, ecnt < 25, ecnt < 25, ecnt == 25);
    end

    // CLR_REQ held through CLEAR: ignored until DONE on 37, re-entry on 38
    clr_a = 1'b1;
    tick();
    expect_a(1'b1, 1'b1, 1'b1, 1'b0);
    for (int e = 28; e <= 37; e++) begin
      tick();
      expect_a(ecnt % 3 == 0, ecnt < 37, ecnt < 37, ecnt == 37);
    end
    tick();
    expect_a(1'b0, 1'b1, 1'b1, 1'b0);
    clr_a = 1'b0;
    for (int e = 39; e <= 50; e++) begin
      tick();
      expect_a(ecnt % 3 == 0, ecnt < 49, ecnt < 49, ecnt == 49);
    end

    // DIV 2->5 mid-period: wrap still on 51, then every 6 cycles (57, 63)
    div_a = 8'd5;
    for (int e = 51; e <= 63; e++) begin
      tick();
      expect_a(ecnt == 51 || ecnt == 57 || ecnt == 63, 1'b0, 1'b0, 1'b0);
    end

    // Enter CLEAR, then SR mid-CLEAR restarts the full HOLD sequence
    clr_a = 1'b1;
    tick();
    expect_a(1'b0, 1'b1, 1'b1, 1'b0);
    clr_a = 1'b0;
    tick();
    expect_a(1'b0, 1'b1, 1'b1, 1'b0);
    sr_a  = 1'b1;
    div_a = 8'd2;
    tick();
    expect_a(1'b0, 1'b1, 1'b1, 1'b0);
    sr_a = 1'b0;
    base = ecnt;
    // CLR_REQ pulsed during HOLD must have no effect
    for (int r = 1; r <= 14; r++) begin
      tick();
      expect_a((ecnt - base) % 3 == 0, (ecnt - base) < 13, (ecnt - base) < 13,
               (ecnt - base) == 13);
      if (r == 5) clr_a = 1'b1;
      if (r == 6) clr_a = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog edge=%0d got=timeout exp=finish", ecnt);
    $fatal(1, "watchdog");
  end

endmodule
